register_file_wb: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register outputs (wb data, rd, register write enable) in the RV32I core. Holds the 32x32 integer register file with x0 hardwired to zero. Provides two combinational read ports to decode with write-through bypass. Keeps a per-register pending-write scoreboard, set at issue and cleared at writeback, that drives decode stall logic.

---
 rtl/register_file_wb_if.sv | 33 +++
 rtl/register_file_wb.sv | 60 ++++++
 tb/tb_register_file_wb.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/register_file_wb_if.sv
// Writeback, read-port and scoreboard signals between the pipeline and the RV32I register file.
// The master drives writeback/issue/read addresses; the slave (register file) returns data and busy.
interface register_file_wb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] wb_data_in;
  logic [AW-1:0]   instruction_rd_in;
  logic            register_write_enable_in;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            flush;
  logic            rs1_busy;
  logic            rs2_busy;

  modport master (
    output wb_data_in, instruction_rd_in, register_write_enable_in,
    output rs1_addr, rs2_addr, issue_valid, issue_rd, flush,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy
  );

  modport slave (
    input  wb_data_in, instruction_rd_in, register_write_enable_in,
    input  rs1_addr, rs2_addr, issue_valid, issue_rd, flush,
    output rs1_data, rs2_data, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/register_file_wb.sv
// RV32I integer register file (x0 hardwired to zero) with write-first bypass on both read ports
// and a per-register pending-write scoreboard feeding decode stall logic.
module register_file_wb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic               clk,
  input logic               rst,
  register_file_wb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_hit;

  assign wr_hit = bus.register_write_enable_in && (bus.instruction_rd_in != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[bus.instruction_rd_in] <= bus.wb_data_in;
    end
  end

  // The issue set is applied after the writeback clear so a new producer wins the same-cycle race.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_hit) busy_nxt[bus.instruction_rd_in] = 1'b0;
      if (bus.issue_valid && (bus.issue_rd != '0)) busy_nxt[bus.issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0)                                     return '0;
    else if (wr_hit && (bus.instruction_rd_in == addr)) return bus.wb_data_in;
    else                                                return regs[addr];
  endfunction

  // Busy is masked while the producer is writing back, matching what the bypass delivers.
  function automatic logic busy_port(input logic [AW-1:0] addr);
    return (addr != '0) && busy[addr] && !(wr_hit && (bus.instruction_rd_in == addr));
  endfunction

  assign bus.rs1_data = read_port(bus.rs1_addr);
  assign bus.rs2_data = read_port(bus.rs2_addr);
  assign bus.rs1_busy = busy_port(bus.rs1_addr);
  assign bus.rs2_busy = busy_port(bus.rs2_addr);
endmodule

// File: tb/tb_register_file_wb.sv
// Randomized plus directed check of register_file_wb against an array-based architectural model.
module tb_register_file_wb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  always #5 clk = ~clk;

  register_file_wb_if #(.XLEN(32), .NREGS(32)) bus ();

  register_file_wb #(.XLEN(32), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic iv, input logic [4:0] ird, input logic fl);
    bus.register_write_enable_in = we;
    bus.instruction_rd_in        = rd;
    bus.wb_data_in               = wd;
    bus.rs1_addr                 = a1;
    bus.rs2_addr                 = a2;
    bus.issue_valid              = iv;
    bus.issue_rd                 = ird;
    bus.flush                    = fl;
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (bus.register_write_enable_in && bus.instruction_rd_in == a) return bus.wb_data_in;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (bus.register_write_enable_in && bus.instruction_rd_in == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_ports();
    chk("rs1_data", bus.rs1_data, exp_data(bus.rs1_addr));
    chk("rs2_data", bus.rs2_data, exp_data(bus.rs2_addr));
    chk("rs1_busy", {31'b0, bus.rs1_busy}, {31'b0, exp_busy(bus.rs1_addr)});
    chk("rs2_busy", {31'b0, bus.rs2_busy}, {31'b0, exp_busy(bus.rs2_addr)});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Commit the currently driven inputs to the model, then cross the rising edge.
  task automatic step();
    int rd;
    int ird;
    rd  = bus.instruction_rd_in;
    ird = bus.issue_rd;
    if (bus.register_write_enable_in && rd != 0) m_regs[rd] = bus.wb_data_in;
    if (bus.flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (bus.register_write_enable_in && rd != 0) m_busy[rd] = 1'b0;
      if (bus.issue_valid && ird != 0) m_busy[ird] = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic iv, input logic [4:0] ird, input logic fl);
    drive(we, rd, wd, a1, a2, iv, ird, fl);
    #1;
    check_ports();
    step();
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.rs1_addr = 5'(i);
      bus.rs2_addr = 5'(31 - i);
      #1;
      chk("reset_rs1_data", bus.rs1_data, 32'h0);
      chk("reset_rs2_data", bus.rs2_data, 32'h0);
      chk("reset_busy", {30'b0, bus.rs1_busy, bus.rs2_busy}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Writeback with bypass, then x0 writes
    drive(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0); #1;
    chk("bypass_x5", bus.rs1_data, 32'hDEADBEEF);
    step();
    drive(0, 0, 0, 5, 0, 0, 0, 0); #1;
    chk("held_x5", bus.rs1_data, 32'hDEADBEEF);
    drive(1, 0, 32'h12345678, 0, 0, 0, 0, 0); #1;
    chk("x0_bypass", bus.rs1_data, 32'h0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("x0_after", bus.rs1_data, 32'h0);

    // Both ports on the written register; second port on an untouched neighbour
    cyc(1, 8, 32'h0BADF00D, 0, 0, 0, 0, 0);
    drive(1, 7, 32'hA5A5A5A5, 7, 7, 0, 0, 0); #1;
    chk("dual_rs1_x7", bus.rs1_data, 32'hA5A5A5A5);
    chk("dual_rs2_x7", bus.rs2_data, 32'hA5A5A5A5);
    step();
    drive(1, 7, 32'h5A5A5A5A, 7, 8, 0, 0, 0); #1;
    chk("rs1_x7_new", bus.rs1_data, 32'h5A5A5A5A);
    chk("rs2_x8_old", bus.rs2_data, 32'h0BADF00D);
    step();

    // Scoreboard set, bypass-masked busy, clear
    cyc(0, 0, 0, 0, 0, 1, 10, 0);
    drive(0, 0, 0, 10, 0, 0, 0, 0); #1;
    chk("busy_x10_set", {31'b0, bus.rs1_busy}, 32'h1);
    drive(1, 10, 32'hCAFE0010, 10, 0, 0, 0, 0); #1;
    chk("busy_x10_wb", {31'b0, bus.rs1_busy}, 32'h0);
    chk("data_x10_wb", bus.rs1_data, 32'hCAFE0010);
    step();
    drive(0, 0, 0, 10, 0, 0, 0, 0); #1;
    chk("busy_x10_clr", {31'b0, bus.rs1_busy}, 32'h0);

    // Set wins over clear on the same edge; issue to x0 is a no-op
    cyc(0, 0, 0, 0, 0, 1, 12, 0);
    cyc(1, 12, 32'h00000012, 0, 0, 1, 12, 0);
    drive(0, 0, 0, 12, 0, 1, 0, 0); #1;
    chk("busy_x12_setwins", {31'b0, bus.rs1_busy}, 32'h1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("busy_x0", {31'b0, bus.rs1_busy}, 32'h0);

    // Flush beats a same-cycle issue but not a same-cycle register write
    cyc(0, 0, 0, 0, 0, 1, 3, 0);
    cyc(0, 0, 0, 0, 0, 1, 4, 0);
    cyc(0, 0, 0, 3, 4, 1, 9, 0);
    cyc(1, 20, 32'h20202020, 9, 6, 1, 6, 1);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 5'(i), 5'(i), 0, 0, 0); #1;
      chk("flush_busy", {31'b0, bus.rs1_busy}, 32'h0);
    end
    drive(0, 0, 0, 20, 0, 0, 0, 0); #1;
    chk("flush_write_x20", bus.rs1_data, 32'h20202020);

    // Randomized traffic, addresses biased toward a small window to force collisions
    for (int n = 0; n < 600; n++) begin
      logic [4:0] rd, a1, a2, ird;
      rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a1  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ird = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), rd, $urandom, a1, a2,
          1'($urandom_range(0, 1)), ird, ($urandom_range(0, 19) == 0));
    end

    // Asynchronous reset mid-cycle, then an in-flight write held under reset
    cyc(1, 15, 32'hF00DF00D, 0, 0, 1, 16, 0);
    drive(0, 0, 0, 15, 16, 0, 0, 0); #1;
    chk("pre_reset_x15", bus.rs1_data, 32'hF00DF00D);
    chk("pre_reset_busy16", {31'b0, bus.rs2_busy}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_x15", bus.rs1_data, 32'h0);
    chk("async_reset_busy16", {31'b0, bus.rs2_busy}, 32'h0);
    model_reset();
    drive(1, 15, 32'h77777777, 0, 0, 1, 15, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 15, 15, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_ports();
    chk("reset_discard_x15", bus.rs1_data, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
